// File: rtl/mips_bus_ram_responder.sv
// Wait-state RAM slave for the mips_cpu_bus master: single-word reads, byte-enabled writes,
// programmable waitrequest stretching and a sticky flag for master protocol violations.
module mips_bus_ram_responder #(
  parameter string       INIT_FILE   = "datamem.txt",
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        protocol_error
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAST    = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_wr;

  logic [31:0] mem [DEPTH];

  logic [31:0] req_word;
  logic [31:0] lat_word;
  logic        req_in_range;
  logic        lat_in_range;
  logic        violation;
  logic        do_write;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Offsets wrap in 32 bits, so addresses below BASE_ADDR land far above DEPTH.
  always_comb begin
    req_word     = (address - BASE_ADDR) >> 2;
    lat_word     = (lat_addr - BASE_ADDR) >> 2;
    req_in_range = (req_word < DEPTH_W);
    lat_in_range = (lat_word < DEPTH_W);
  end

  // Exactly one of read/write must stay asserted, with the latched op and address.
  always_comb begin
    violation = 1'b0;
    if (state == BUSY || state == DONE)
      violation = (read == write) || (write != lat_wr) || (address != lat_addr);
  end

  always_comb begin
    waitrequest = (state != DONE) && (read || write);
    do_write    = (state == DONE) && lat_wr && lat_in_range && !violation && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_be         <= '0;
      lat_wr         <= 1'b0;
      readdata       <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read && write) begin
            protocol_error <= 1'b1;
          end else if (read || write) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_wr    <= write;
            cnt       <= 4'd1;
            if (!req_in_range) protocol_error <= 1'b1;
            if (WAIT_CYCLES == 1) begin
              state <= DONE;
              if (read) readdata <= req_in_range ? mem[req_word[AW-1:0]] : '0;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (violation) begin
            protocol_error <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST) begin
              state <= DONE;
              if (!lat_wr) readdata <= lat_in_range ? mem[lat_word[AW-1:0]] : '0;
            end
          end
        end
        DONE: begin
          if (violation) protocol_error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < 4; i++)
        if (lat_be[i]) mem[lat_word[AW-1:0]][8*i +: 8] <= lat_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_mips_bus_ram_responder.sv
// Bench for mips_bus_ram_responder: two instances (3 and 1 wait states) driven with
// directed and random accesses, checked against an array-based memory model.
module tb_mips_bus_ram_responder;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int unsigned NW   = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address     [2];
  logic        write       [2];
  logic        read        [2];
  logic        waitrequest [2];
  logic [31:0] writedata   [2];
  logic [3:0]  byteenable  [2];
  logic [31:0] readdata    [2];
  logic        perr        [2];

  int unsigned wc [2] = '{3, 1};
  logic [31:0] mdl [2][NW];
  logic        perr_m [2];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mips_bus_ram_responder #(.INIT_FILE(""), .BASE_ADDR(BASE), .DEPTH(NW), .WAIT_CYCLES(3)) u0 (
    .clk(clk), .rst(rst), .address(address[0]), .write(write[0]), .read(read[0]),
    .waitrequest(waitrequest[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
    .readdata(readdata[0]), .protocol_error(perr[0]));

  mips_bus_ram_responder #(.INIT_FILE(""), .BASE_ADDR(BASE), .DEPTH(NW), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .address(address[1]), .write(write[1]), .read(read[1]),
    .waitrequest(waitrequest[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
    .readdata(readdata[1]), .protocol_error(perr[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete bus access as a well-behaved master: hold the request until
  // waitrequest drops, keep it through that cycle, then release.
  task automatic access(input int u, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
    int          waits;
    logic [31:0] w;
    logic [31:0] exp;
    w = (a - BASE) >> 2;
    @(negedge clk);
    address[u] = a; writedata[u] = d; byteenable[u] = be;
    read[u] = !wr; write[u] = wr;
    #1;
    waits = 0;
    while (waitrequest[u] && waits < 64) begin
      waits++;
      @(negedge clk);
      #1;
    end
    check({tag, " waits"}, 32'(waits), 32'(wc[u]));
    if (!wr) begin
      exp = (w < NW) ? mdl[u][w[10:0]] : 32'h0;
      check({tag, " rdata"}, readdata[u], exp);
    end else if (w < NW) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[u][w[10:0]][8*i +: 8] = d[8*i +: 8];
    end
    if (w >= NW) perr_m[u] = 1'b1;
    @(negedge clk);
    read[u] = 1'b0; write[u] = 1'b0;
    #1;
    check({tag, " perr"}, 32'(perr[u]), 32'(perr_m[u]));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < int'(NW); i++) mdl[u][i] = '0;
      perr_m[u] = 1'b0;
      address[u] = '0; write[u] = 1'b0; read[u] = 1'b0;
      writedata[u] = '0; byteenable[u] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset wreq", 32'(waitrequest[u]), 32'h0);
      check("reset rdata", readdata[u], 32'h0);
      check("reset perr", 32'(perr[u]), 32'h0);
    end

    // Single-wait-state instruction fetch of word 0.
    access(1, 1'b1, BASE, 32'h24020005, 4'hF, "u1 load w0");
    access(1, 1'b0, BASE, 32'h0, 4'h0, "u1 read w0");
    check("u1 w0 value", readdata[1], 32'h24020005);

    // Three wait states, write then read back.
    access(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, "u0 wr 10");
    access(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "u0 rd 10");
    check("u0 deadbeef", readdata[0], 32'hDEADBEEF);

    // Byte-lane merge and empty byteenable.
    access(0, 1'b1, BASE + 32'h40, 32'h11223344, 4'hF, "u0 pre 40");
    access(0, 1'b1, BASE + 32'h40, 32'hAABBCCDD, 4'b0101, "u0 be0101");
    access(0, 1'b0, BASE + 32'h40, 32'h0, 4'h0, "u0 rd be0101");
    check("u0 merged", readdata[0], 32'h11BB33DD);
    access(0, 1'b1, BASE + 32'h40, 32'hFFFFFFFF, 4'b0000, "u0 be0000");
    access(0, 1'b0, BASE + 32'h40, 32'h0, 4'h0, "u0 rd be0000");
    check("u0 unchanged", readdata[0], 32'h11BB33DD);

    // Random in-range traffic; low address bits are noise.
    for (int n = 0; n < 80; n++) begin
      int          u;
      bit          wr;
      logic [31:0] a;
      u  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
      access(u, wr, a, $urandom, 4'($urandom_range(0, 15)), wr ? "rnd wr" : "rnd rd");
    end

    // Reset in the middle of a write's wait states.
    @(negedge clk);
    address[0] = BASE + 32'h20; writedata[0] = 32'hCAFEF00D; byteenable[0] = 4'hF;
    write[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst wreq held", 32'(waitrequest[0]), 32'h1);
    check("rst rdata", readdata[0], 32'h0);
    @(negedge clk);
    write[0] = 1'b0;
    #1;
    check("rst wreq idle", 32'(waitrequest[0]), 32'h0);
    rst = 1'b0;
    perr_m[0] = 1'b0; perr_m[1] = 1'b0;
    #1;
    check("post rst rdata", readdata[0], 32'h0);
    check("post rst perr", 32'(perr[0]), 32'h0);
    access(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, "u0 rd after rst");

    // Master drops read while stalled.
    @(negedge clk);
    address[0] = BASE + 32'h8; read[0] = 1'b1;
    @(negedge clk);
    read[0] = 1'b0;
    @(negedge clk);
    #1;
    perr_m[0] = 1'b1;
    check("drop perr", 32'(perr[0]), 32'h1);
    check("drop wreq", 32'(waitrequest[0]), 32'h0);
    access(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0, "u0 after drop");

    // read and write together.
    @(negedge clk);
    address[1] = BASE; read[1] = 1'b1; write[1] = 1'b1;
    #1;
    check("rw wreq", 32'(waitrequest[1]), 32'h1);
    @(negedge clk);
    read[1] = 1'b0; write[1] = 1'b0;
    #1;
    perr_m[1] = 1'b1;
    check("rw perr", 32'(perr[1]), 32'h1);
    access(1, 1'b0, BASE, 32'h0, 4'h0, "u1 after rw");

    // Outside the window: below base wraps high, and one past the end.
    access(0, 1'b0, 32'h00000000, 32'h0, 4'h0, "u0 rd below");
    access(1, 1'b0, BASE + 32'h2000, 32'h0, 4'h0, "u1 rd past end");
    access(0, 1'b1, BASE + 32'h2000, 32'hFFFFFFFF, 4'hF, "u0 wr past end");
    access(0, 1'b0, BASE, 32'h0, 4'h0, "u0 w0 intact");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
